uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter between `NUM_REQ` independent byte sources. Each requester offers bytes over a valid/ready handshake and may lock the transmitter for a multi-byte packet. The arbiter forwards one byte at a time to the transmitter, then waits for that transmission to finish before accepting the next. It sits between the command/telemetry producers and the UART transmit datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 8: maximum bytes per grant before forced rotation (1..255).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte on its data lane.
- `req_data` in 8*NUM_REQ: byte lanes; lane i is `req_data[8*i+7:8*i]`.
- `req_last` in NUM_REQ: the current byte is the final byte of the packet.
- `req_ready` out NUM_REQ: byte accepted from requester i on this edge (one-hot or zero).
- `tx_data` out 8: byte presented to the transmitter; registered.
- `tx_start` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy` in 1: transmitter is sending a frame (start bit through stop bit).
- `grant_id` out clog2(NUM_REQ): index of the current or last granted requester.
- `active` out 1: a grant is held (any state other than IDLE).

## Operation
- States: IDLE, SEND, WAIT_START, WAIT_DONE.
- Rotating pointer `ptr`, reset 0. Winner = first i with `req_valid[i]` set, searching ptr, ptr+1, … modulo NUM_REQ.
- IDLE: if any `req_valid` is set, register the winner into `grant_id`, clear `burst_cnt`, and go to SEND. Otherwise stay.
- SEND: `req_ready[grant_id] = req_valid[grant_id] & ~tx_busy`, combinational. All other `req_ready` bits are 0.
  - On accept: `tx_data <= lane`, `tx_start <= 1`, `burst_cnt <= burst_cnt+1`, latch `last_q <= req_last[grant_id] | (burst_cnt == MAX_BURST-1)`, go to WAIT_START.
  - With no valid byte, stay in SEND; the lock is held.
- WAIT_START: `tx_start` is high for exactly one cycle. Wait for `tx_busy = 1`, then go to WAIT_DONE.
- WAIT_DONE: on `tx_busy = 0`:
  - If `last_q = 0`, go to SEND.
  - Otherwise set `ptr <= grant_id+1` (wrapping NUM_REQ-1 → 0) and go to IDLE.
- Packet lock: once granted, a requester keeps the transmitter until it sends a byte with `req_last` set or until MAX_BURST bytes have been sent. Requesters must keep packet bytes contiguous. The arbiter does not time out a stalled lock.
- `burst_cnt` is clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
- Reset values: `req_ready = 0`, `tx_data = 8'h00`, `tx_start = 0`, `grant_id = 0`, `active = 0`. State is IDLE, `ptr = 0`.
- Reset mid-operation: everything returns to the reset values immediately. The transmitter's own reset aborts any frame in progress.

## Timing
- Request to first accept: `req_valid` seen in IDLE at edge N gives grant at N+1. `req_ready` is high during cycle N+1 and the byte is captured at edge N+2.
- `tx_start` is high for the single cycle following the accept edge, and `tx_data` is stable from that cycle until the next accept.
- Next accept in the same packet: first cycle after `tx_busy` falls, plus one cycle in SEND.
- Simultaneous requests: exactly one is granted, per the `ptr` order. Requests from non-granted requesters stay pending; their `req_ready` stays low.
- A `req_valid` deasserted before accept is legal and produces no transfer.
- If `tx_busy` is already high in SEND (transmitter still busy from another source), no accept occurs.
- `active = (state != IDLE)`, registered from state.

## Structure
- Shared package `uart_pkg`: state enumeration `arb_state_t` and the default constants NUM_REQ and MAX_BURST.
- Sub-module `rr_pick`: a combinational priority rotator with inputs `req`, `ptr` and outputs `found`, `idx`. It is reusable by the future RX dispatcher.
- Remaining logic (FSM, counters, output registers) stays in `uart_tx_arbiter`.

## Test plan
- Single byte: requester 2 sends `0x5A` with `req_last = 1`.
  - Expect one `tx_start`, `tx_data = 0x5A`, `grant_id = 2`.
  - Expect `ptr` to become 3 and a return to IDLE after `tx_busy` falls.
- Contention: all four requesters valid with `last = 1` after reset. Expect grant order 0, 1, 2, 3, 0, with no `req_ready` overlap.
- Packet lock: requester 1 sends `0x11, 0x22, 0x33` (last on `0x33`) while requester 0 stays valid.
  - Expect all three bytes transmitted back-to-back before requester 0 is granted.
- Burst limit: with MAX_BURST = 4, requester 3 sends 6 bytes and requester 0 is valid.
  - Expect requester 3 to lose the grant after 4 bytes, then requester 0 to be granted, then requester 3 to resume.
- Backpressure: hold `tx_busy = 1` externally while in SEND. Expect `req_ready` to stay 0 until `tx_busy` drops, then the accept to complete.
- Reset mid-frame: assert `rst` low during WAIT_DONE.
  - Expect all outputs at reset values in the same cycle.
  - After release, expect arbitration to restart at requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// at or after ptr, wrapping modulo N. Kept generic for reuse on the RX side.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W:0]     ptr_ext;

  // rotated[k] is the request that sits k positions after ptr
  assign doubled = {req, req};
  assign ptr_ext = {1'b0, ptr};
  assign rotated = doubled[ptr_ext +: N];

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
    logic [W:0] sum;
    sum = {1'b0, base} + (W+1)'(off);
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    return sum[W-1:0];
  endfunction

  // Scan from the far end so the nearest request to ptr wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found = 1'b1;
        idx   = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ
// byte sources, with packet locking and a per-grant burst limit.
//
// state         | meaning
// ST_IDLE       | no grant held; pick next requester from ptr
// ST_SEND       | grant held; waiting for a byte while transmitter idle
// ST_WAIT_START | byte handed off; waiting for transmitter to go busy
// ST_WAIT_DONE  | frame in flight; on completion continue packet or release
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [IW-1:0] ptr;
  logic [BW-1:0] burst_cnt;
  logic          last_q;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [7:0]    lane;
  logic          lane_valid;
  logic          lane_last;
  logic          accept;
  logic          grant_load;
  logic          release_grant;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Mux the granted requester's lane, valid and last onto shared wires
  always_comb begin
    lane       = '0;
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        lane       = req_data[8*i +: 8];
        lane_valid = req_valid[i];
        lane_last  = req_last[i];
      end
    end
  end

  // Next-state and handshake decode; req_ready only ever targets the grantee
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    grant_load    = 1'b0;
    release_grant = 1'b0;
    req_ready     = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_load = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (lane_valid && !tx_busy) begin
          accept              = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_next          = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (tx_busy) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            release_grant = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Grant capture and round-robin pointer advance on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      if (grant_load) grant_id <= pick_idx;
      if (release_grant) ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Burst counter and end-of-grant flag; the limit forces a release like req_last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
      last_q    <= 1'b0;
    end else if (grant_load) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + 1'b1;
      last_q    <= lane_last | (burst_cnt == BURST_END);
    end
  end

  // Transmitter outputs: data held until next accept, start is a single pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      tx_start <= accept;
      if (accept) tx_data <= lane;
    end
  end

  // Registered grant-held indicator, tracking the state register exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else      active <= (state_next != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a scoreboard of expected
// (grant_id, tx_data) pairs and a simple transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int FRAME = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;

  int total = 0;
  int bad   = 0;

  logic [8:0] src_q [NR][$];
  logic [9:0] exp_q [$];
  int         start_cyc [$];
  int         busy_cnt;
  logic       force_busy;
  int         cyc = 0;
  int         start_count = 0;
  logic [NR-1:0] ready_s;
  logic       start_s;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for FRAME cycles after each start pulse
  always @(posedge clk or negedge rst) begin
    if (!rst)          busy_cnt <= 0;
    else if (tx_start) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0) | force_busy;

  task automatic drive_sources();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = h[7:0];
        req_last[i]         = h[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    ready_s = req_ready;
    start_s = tx_start;
    total++;
    if (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0)) begin
      bad++;
      $display("FAIL ready_onehot: req_ready=%b req_valid=%b, required one-hot subset of valid",
               req_ready, req_valid);
    end
    if (tx_start) begin
      start_count++;
      start_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: id=%0d data=%h, required no transfer", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, tx_data} !== e) begin
          bad++;
          $display("FAIL tx_byte: id=%0d data=%h, required id=%0d data=%h",
                   grant_id, tx_data, e[9:8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (ready_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_sources();
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = srcs_empty() && (exp_q.size() == 0) && !active && !tx_busy;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: exp_left=%0d active=%b, required drained and idle",
               name, exp_q.size(), active);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    force_busy = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: %b, required 0000", req_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: %h, required 00", tx_data); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: %b, required 0", tx_start); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id: %0d, required 0", grant_id); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active: %b, required 0", active); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int sc0;
    sc0 = start_count;
    src_q[2].push_back({1'b1, 8'h5A});
    exp_q.push_back({2'd2, 8'h5A});
    drive_sources();
    step();
    total++; if (ready_s !== 4'b0000) begin bad++; $display("FAIL single_ready_idle: %b, required 0000", ready_s); end
    step();
    total++; if (ready_s !== 4'b0100) begin bad++; $display("FAIL single_ready_grant: %b, required 0100", ready_s); end
    step();
    total++; if (start_s !== 1'b1) begin bad++; $display("FAIL single_start_timing: %b, required 1", start_s); end
    run_until_idle(40, "single");
    total++; if (start_count - sc0 != 1) begin bad++; $display("FAIL single_start_count: %0d, required 1", start_count - sc0); end
  endtask

  task automatic test_ptr_advance();
    src_q[0].push_back({1'b1, 8'hA0});
    src_q[3].push_back({1'b1, 8'hA3});
    exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd0, 8'hA0});
    drive_sources();
    run_until_idle(60, "ptr_advance");
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      src_q[i].push_back({1'b1, 8'hC0 | 8'(i)});
      exp_q.push_back({2'(i), 8'hC0 | 8'(i)});
    end
    src_q[0].push_back({1'b1, 8'hC4});
    exp_q.push_back({2'd0, 8'hC4});
    drive_sources();
    run_until_idle(120, "contention");
  endtask

  task automatic test_packet_lock();
    start_cyc.delete();
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h22});
    src_q[1].push_back({1'b1, 8'h33});
    src_q[0].push_back({1'b1, 8'h0F});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd1, 8'h33});
    exp_q.push_back({2'd0, 8'h0F});
    drive_sources();
    run_until_idle(100, "packet_lock");
    total++;
    if (start_cyc.size() != 4) begin
      bad++;
      $display("FAIL lock_start_count: %0d, required 4", start_cyc.size());
    end else begin
      if (start_cyc[1] - start_cyc[0] != FRAME + 3) begin
        bad++; $display("FAIL lock_gap1: %0d, required %0d", start_cyc[1] - start_cyc[0], FRAME + 3);
      end
      total++;
      if (start_cyc[2] - start_cyc[1] != FRAME + 3) begin
        bad++; $display("FAIL lock_gap2: %0d, required %0d", start_cyc[2] - start_cyc[1], FRAME + 3);
      end
      total++;
      if (start_cyc[3] - start_cyc[2] != FRAME + 4) begin
        bad++; $display("FAIL lock_regrant_gap: %0d, required %0d", start_cyc[3] - start_cyc[2], FRAME + 4);
      end
    end
  endtask

  task automatic test_burst_limit();
    for (int i = 1; i <= 6; i++) src_q[3].push_back({(i == 6), 8'hB0 | 8'(i)});
    src_q[0].push_back({1'b1, 8'h0E});
    for (int i = 1; i <= 4; i++) exp_q.push_back({2'd3, 8'hB0 | 8'(i)});
    exp_q.push_back({2'd0, 8'h0E});
    for (int i = 5; i <= 6; i++) exp_q.push_back({2'd3, 8'hB0 | 8'(i)});
    drive_sources();
    run_until_idle(150, "burst_limit");
  endtask

  task automatic test_backpressure();
    force_busy = 1'b1;
    src_q[2].push_back({1'b1, 8'h77});
    exp_q.push_back({2'd2, 8'h77});
    drive_sources();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (ready_s !== 4'b0000 || start_s !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: ready=%b start=%b, required 0000/0", ready_s, start_s);
      end
    end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL bp_active: %b, required 1", active); end
    force_busy = 1'b0;
    run_until_idle(40, "backpressure");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    src_q[1].push_back({1'b1, 8'hD1});
    exp_q.push_back({2'd1, 8'hD1});
    drive_sources();
    start_s = 1'b0;
    n = 0;
    while (!start_s && n < 20) begin step(); n++; end
    total++;
    if (!start_s) begin bad++; $display("FAIL rmf_start_timeout: start=%b, required 1", start_s); end
    step();
    step();
    #3 rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmf_ready: %b, required 0000", req_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmf_tx_data: %h, required 00", tx_data); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmf_tx_start: %b, required 0", tx_start); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmf_grant_id: %0d, required 0", grant_id); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rmf_active: %b, required 0", active); end
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    src_q[0].push_back({1'b1, 8'hE0});
    src_q[3].push_back({1'b1, 8'hE3});
    exp_q.push_back({2'd0, 8'hE0});
    exp_q.push_back({2'd3, 8'hE3});
    drive_sources();
    run_until_idle(60, "restart");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    force_busy = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_ptr_advance();
    test_contention();
    test_packet_lock();
    test_burst_limit();
    test_backpressure();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
